// File: rtl/div_iter_unit_pkg.sv
// Shared types and defaults for the iterative divider.
package div_iter_unit_pkg;

  // Divider sequencing: wait for a request, iterate, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEPS = 1;

endpackage

// File: rtl/div_iter_unit_if.sv
// Request/response bundle between EX (master) and the divider (slave).
interface div_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               dbz_o;
  logic               busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbz_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbz_o, busy_o
  );
endinterface

// File: rtl/div_iter_unit_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference when it is non-negative.
module div_iter_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           quo_bit;

  // rem < div on entry, so the shifted value is below 2*div and the
  // WIDTH+1-bit difference never overflows; its MSB is the sign.
  always_comb begin
    rem_sh  = {rem_i, quo_i[WIDTH-1]};
    trial   = rem_sh - {1'b0, div_i};
    quo_bit = ~trial[WIDTH];
    rem_o   = quo_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], quo_bit};
  end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned divider, STEPS quotient bits per clock.
// The quotient register starts out holding |dividend|; its bits shift into
// the remainder from the top while quotient bits fill in from the bottom.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEPS = DEF_STEPS
) (
  input  logic             clk,
  input  logic             rst,
  div_iter_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sign_dvd_q, sign_dvd_d;
  logic               sign_dvs_q, sign_dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   rem_chain [STEPS+1];
  logic [WIDTH-1:0]   quo_chain [STEPS+1];

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      div_iter_unit_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_chain[gi]),
        .quo_i (quo_chain[gi]),
        .div_i (dvs_q),
        .rem_o (rem_chain[gi+1]),
        .quo_o (quo_chain[gi+1])
      );
    end
  endgenerate

  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes for capture, and sign correction of the final step's output.
  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    dvd_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    dvs_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    quo_fix = (sign_dvd_q ^ sign_dvs_q) ? -quo_chain[STEPS] : quo_chain[STEPS];
    rem_fix = sign_dvd_q ? -rem_chain[STEPS] : rem_chain[STEPS];
  end

  // Next-state and datapath updates; annul overrides everything else.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sign_dvd_d = sign_dvd_q;
    sign_dvs_d = sign_dvs_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    dbz_d      = dbz_q;

    if (bus.annul_i) begin
      state_d = ST_IDLE;
      dbz_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (bus.opdata2_i == '0) begin
              state_d  = ST_DONE;
              result_d = '0;
              dbz_d    = 1'b1;
            end else begin
              state_d    = ST_CALC;
              quo_d      = dvd_abs;
              dvs_d      = dvs_abs;
              rem_d      = '0;
              sign_dvd_d = op1_neg;
              sign_dvs_d = op2_neg;
              cnt_d      = '0;
              dbz_d      = 1'b0;
            end
          end
        end
        ST_CALC: begin
          rem_d = rem_chain[STEPS];
          quo_d = quo_chain[STEPS];
          cnt_d = cnt_q + CW'(STEPS);
          if (cnt_q == CW'(WIDTH - STEPS)) begin
            state_d  = ST_DONE;
            result_d = {rem_fix, quo_fix};
          end
        end
        ST_DONE: begin
          if (!bus.start_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sign_dvd_q <= sign_dvd_d;
      sign_dvs_q <= sign_dvs_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = (state_q == ST_DONE);
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.dbz_o    = dbz_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench: a 32-bit/1-step and a 16-bit/4-step divider.
module tb_div_iter_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   edges;

  div_iter_unit_if #(.WIDTH(32)) bus32 ();
  div_iter_unit_if #(.WIDTH(16)) bus16 ();

  div_iter_unit #(.WIDTH(32), .STEPS(1)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  div_iter_unit #(.WIDTH(16), .STEPS(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  // Raise start with the given operands and count edges until ready_o.
  task automatic run32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    bus32.signed_div_i = sg;
    bus32.opdata1_i    = a;
    bus32.opdata2_i    = b;
    bus32.start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus32.ready_o && n < 200);
  endtask

  task automatic run16(input logic sg, input logic [15:0] a, input logic [15:0] b,
                       output int n);
    bus16.signed_div_i = sg;
    bus16.opdata1_i    = a;
    bus16.opdata2_i    = b;
    bus16.start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus16.ready_o && n < 200);
  endtask

  task automatic release32();
    bus32.start_i = 1'b0;
    tick();
    check("rel32_ready_busy", {62'b0, bus32.ready_o, bus32.busy_o}, 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    bus32.signed_div_i = 1'b0; bus32.opdata1_i = '0; bus32.opdata2_i = '0;
    bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
    bus16.signed_div_i = 1'b0; bus16.opdata1_i = '0; bus16.opdata2_i = '0;
    bus16.start_i = 1'b0; bus16.annul_i = 1'b0;

    tick();
    tick();
    check("reset_result", bus32.result_o, 64'd0);
    check("reset_flags", {61'b0, bus32.ready_o, bus32.dbz_o, bus32.busy_o}, 64'd0);
    rst = 1'b1;
    tick();

    // Unsigned 100/7: {rem 2, quo 14} after 33 edges.
    run32(1'b0, 32'd100, 32'd7, edges);
    check("u100_7_latency", 64'(edges), 64'd33);
    check("u100_7_result", bus32.result_o, 64'h00000002_0000000E);
    release32();

    // Signed truncating division in both sign combinations.
    run32(1'b1, 32'hFFFFFFF9, 32'd2, edges);
    check("s-7_2_result", bus32.result_o, 64'hFFFFFFFF_FFFFFFFD);
    release32();
    run32(1'b1, 32'd7, 32'hFFFFFFFE, edges);
    check("s7_-2_result", bus32.result_o, 64'h00000001_FFFFFFFD);
    release32();

    // Large unsigned dividend, abs must not be applied.
    run32(1'b0, 32'hFFFFFFFF, 32'h10, edges);
    check("uFFFF_16_result", bus32.result_o, 64'h0000000F_0FFFFFFF);
    release32();

    // Annul at CALC cycle 10: back to IDLE, result untouched.
    bus32.signed_div_i = 1'b0; bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
    bus32.start_i = 1'b1;
    tick();
    repeat (10) tick();
    check("calc_busy", {63'b0, bus32.busy_o}, 64'd1);
    bus32.annul_i = 1'b1;
    bus32.start_i = 1'b0;
    tick();
    bus32.annul_i = 1'b0;
    check("annul_flags", {61'b0, bus32.ready_o, bus32.dbz_o, bus32.busy_o}, 64'd0);
    check("annul_result_kept", bus32.result_o, 64'h0000000F_0FFFFFFF);
    repeat (3) tick();
    check("annul_stays_idle", {62'b0, bus32.ready_o, bus32.busy_o}, 64'd0);
    run32(1'b0, 32'd1000, 32'd9, edges);
    check("after_annul_latency", 64'(edges), 64'd33);
    check("after_annul_result", bus32.result_o, 64'h00000001_0000006F);
    release32();

    // Divide by zero: DONE after one edge, zero result, dbz flagged.
    run32(1'b0, 32'd5, 32'd0, edges);
    check("dbz_latency", 64'(edges), 64'd1);
    check("dbz_result", bus32.result_o, 64'd0);
    check("dbz_flag", {63'b0, bus32.dbz_o}, 64'd1);
    release32();

    // start dropped mid-CALC, operands changed: result completes, ready for one cycle.
    bus32.signed_div_i = 1'b0; bus32.opdata1_i = 32'd50; bus32.opdata2_i = 32'd5;
    bus32.start_i = 1'b1;
    tick();
    bus32.opdata1_i = 32'd999;
    bus32.opdata2_i = 32'd2;
    tick();
    tick();
    bus32.start_i = 1'b0;
    repeat (30) tick();
    check("drop_start_ready", {63'b0, bus32.ready_o}, 64'd1);
    check("drop_start_result", bus32.result_o, 64'h00000000_0000000A);
    tick();
    check("drop_start_one_cycle", {62'b0, bus32.ready_o, bus32.busy_o}, 64'd0);

    // Reset in the middle of a calculation.
    run32(1'b0, 32'd77, 32'd7, edges);
    release32();
    bus32.opdata1_i = 32'd12345; bus32.opdata2_i = 32'd6; bus32.start_i = 1'b1;
    repeat (6) tick();
    rst = 1'b0;
    tick();
    check("midreset_result", bus32.result_o, 64'd0);
    check("midreset_flags", {61'b0, bus32.ready_o, bus32.dbz_o, bus32.busy_o}, 64'd0);
    rst = 1'b1;
    bus32.start_i = 1'b0;
    tick();

    // Signed overflow MIN / -1.
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, edges);
    check("smin_-1_latency", 64'(edges), 64'd33);
    check("smin_-1_result", bus32.result_o, 64'h00000000_80000000);
    release32();

    // 16-bit, 4 bits per clock: 0xFFFF/3 in 5 edges, held in DONE.
    run16(1'b0, 16'hFFFF, 16'h0003, edges);
    check("w16_latency", 64'(edges), 64'd5);
    check("w16_result", {32'b0, bus16.result_o}, 64'h0000_5555);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w16_hold", {31'b0, bus16.ready_o, bus16.result_o}, 64'h1_0000_5555);
    end
    bus16.start_i = 1'b0;
    tick();
    check("w16_release", {62'b0, bus16.ready_o, bus16.busy_o}, 64'd0);

    run16(1'b1, 16'hFF9C, 16'd7, edges);
    check("w16_s-100_7", {32'b0, bus16.result_o}, 64'hFFFE_FFF2);
    bus16.start_i = 1'b0;
    tick();
    run16(1'b1, 16'h8000, 16'hFFFF, edges);
    check("w16_smin_-1", {32'b0, bus16.result_o}, 64'h0000_8000);
    bus16.start_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
